// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART echo link tester.
// Holds the tester state encoding, ASCII constants and the bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_WAIT_RX,
    S_CHECK,
    S_NEXT,
    S_DONE
  } tester_state_t;

  localparam logic [7:0] CHAR_A = 8'h41;
  localparam logic [7:0] CHAR_Z = 8'h5A;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module uart_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_echo_tester.sv
// Initiator end of a UART echo link: sends a byte pattern, checks echoes.
// Define UART_TESTER_GAP_EN to insert GAP_BITS idle bit periods between bytes.
module uart_echo_tester
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 25_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned NUM_BYTES    = 26,
  parameter logic [7:0]  FIRST_CHAR   = CHAR_A,
  parameter int unsigned PATTERN_LEN  = 26,
  parameter int unsigned TIMEOUT_BITS = 30,
  parameter int unsigned CNT_W        = 16
`ifdef UART_TESTER_GAP_EN
  ,
  parameter int unsigned GAP_BITS     = 2
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_tx_dv,
  output logic [7:0]       o_tx_byte,
  input  logic             i_tx_active,
  input  logic             i_tx_done,
  input  logic             i_rx_dv,
  input  logic [7:0]       i_rx_byte,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_tmo_cnt,
  output logic [7:0]       o_last_exp,
  output logic [7:0]       o_last_got
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam logic [31:0] TMO_LAST = 32'(CPB * TIMEOUT_BITS - 1);
  localparam logic [7:0]  PAT_LAST = 8'(PATTERN_LEN - 1);
`ifdef UART_TESTER_GAP_EN
  localparam logic [31:0] GAP_CYC = 32'(GAP_BITS * CPB);
`else
  localparam logic [31:0] GAP_CYC = 32'd0;
`endif

  tester_state_t state_q;
  logic [31:0]   idx_q;
  logic [7:0]    phase_q;
  logic [31:0]   timer_q;
  logic          rx_dv_q;
  logic          pend_q;
  logic [7:0]    pend_byte_q;
  logic [7:0]    got_q;
  logic          tx_dv_q;
  logic [7:0]    tx_byte_q;
  logic          done_q;
  logic          pass_q;
  logic [7:0]    last_exp_q;
  logic [7:0]    last_got_q;

  logic       rx_evt;
  logic       rx_hit;
  logic [7:0] rx_byte_d;
  logic       armed;
  logic       match;
  logic       last;
  logic [7:0] pat_byte;
  logic [7:0] phase_d;
  logic       clr;
  logic       pass_inc;
  logic       err_inc;
  logic       tmo_inc;

  assign rx_evt    = i_rx_dv & ~rx_dv_q;
  assign rx_hit    = rx_evt | pend_q;
  assign rx_byte_d = pend_q ? pend_byte_q : i_rx_byte;
  assign armed     = (state_q == S_SEND) || (state_q == S_WAIT_TX);
  assign match     = (got_q == tx_byte_q);
  assign last      = (NUM_BYTES != 0) && ((idx_q + 32'd1) == NUM_BYTES);
  assign pat_byte  = FIRST_CHAR + phase_q;
  assign phase_d   = (phase_q == PAT_LAST) ? 8'd0 : phase_q + 8'd1;

  assign clr      = (state_q == S_IDLE) && i_start && !i_abort;
  assign pass_inc = !i_abort && (state_q == S_CHECK) && match;
  assign err_inc  = !i_abort && (state_q == S_CHECK) && !match;
  assign tmo_inc  = !i_abort && (state_q == S_WAIT_RX) && !rx_hit &&
                    (timer_q == TMO_LAST);

  uart_sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .clr_i (clr),
    .inc_i (pass_inc),
    .cnt_o (o_pass_cnt)
  );

  uart_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .clr_i (clr),
    .inc_i (err_inc),
    .cnt_o (o_err_cnt)
  );

  uart_sat_counter #(.W(CNT_W)) u_tmo_cnt (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .clr_i (clr),
    .inc_i (tmo_inc),
    .cnt_o (o_tmo_cnt)
  );

  // Run sequencer; an echo seen before WAIT_RX is parked in pend_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      phase_q     <= '0;
      timer_q     <= '0;
      rx_dv_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      got_q       <= '0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      last_exp_q  <= '0;
      last_got_q  <= '0;
    end else begin
      rx_dv_q <= i_rx_dv;
      tx_dv_q <= 1'b0;
      done_q  <= 1'b0;
      if (armed && rx_evt) begin
        pend_q      <= 1'b1;
        pend_byte_q <= i_rx_byte;
      end
      if (i_abort && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        pend_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              state_q    <= S_SEND;
              idx_q      <= '0;
              phase_q    <= '0;
              pass_q     <= 1'b0;
              last_exp_q <= '0;
              last_got_q <= '0;
              pend_q     <= 1'b0;
            end
          end
          S_SEND: begin
            if (!i_tx_active) begin
              tx_dv_q   <= 1'b1;
              tx_byte_q <= pat_byte;
              state_q   <= S_WAIT_TX;
            end
          end
          S_WAIT_TX: begin
            if (i_tx_done) begin
              timer_q <= '0;
              state_q <= S_WAIT_RX;
            end
          end
          S_WAIT_RX: begin
            if (rx_hit) begin
              got_q   <= rx_byte_d;
              pend_q  <= 1'b0;
              state_q <= S_CHECK;
            end else if (timer_q == TMO_LAST) begin
              timer_q <= '0;
              state_q <= S_NEXT;
            end else begin
              timer_q <= timer_q + 32'd1;
            end
          end
          S_CHECK: begin
            if (!match) begin
              last_exp_q <= tx_byte_q;
              last_got_q <= got_q;
            end
            timer_q <= '0;
            state_q <= S_NEXT;
          end
          S_NEXT: begin
            if (timer_q == GAP_CYC) begin
              idx_q   <= idx_q + 32'd1;
              phase_q <= phase_d;
              if (last) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                pass_q  <= (o_err_cnt == '0) && (o_tmo_cnt == '0);
              end else begin
                state_q <= S_SEND;
              end
            end else begin
              timer_q <= timer_q + 32'd1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_busy     = (state_q != S_IDLE);
  assign o_tx_dv    = tx_dv_q;
  assign o_tx_byte  = tx_byte_q;
  assign o_done     = done_q;
  assign o_pass     = pass_q;
  assign o_last_exp = last_exp_q;
  assign o_last_got = last_got_q;

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester with a behavioural UART link model.
// Instance A: 4-byte runs; instance B: continuous mode with 8-bit counters.
module tb_uart_echo_tester;

  localparam int FRAME_A = 100;
  localparam int DLY_A   = 20;
  localparam int FRAME_B = 2;
  localparam int DLY_B   = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  logic        start_a = 0, abort_a = 0;
  logic        tx_active_a = 0, tx_done_a = 0, rx_dv_a = 0;
  logic [7:0]  rx_byte_a = 0;
  logic        tx_dv_a, busy_a, done_a, pass_a;
  logic [7:0]  tx_byte_a, last_exp_a, last_got_a;
  logic [15:0] pass_cnt_a, err_cnt_a, tmo_cnt_a;

  logic        start_b = 0, abort_b = 0;
  logic        tx_active_b = 0, tx_done_b = 0, rx_dv_b = 0;
  logic [7:0]  rx_byte_b = 0;
  logic        tx_dv_b, busy_b, done_b, pass_b;
  logic [7:0]  tx_byte_b, last_exp_b, last_got_b;
  logic [7:0]  pass_cnt_b, err_cnt_b, tmo_cnt_b;

  uart_echo_tester #(
    .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .NUM_BYTES(4)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_abort(abort_a),
    .o_tx_dv(tx_dv_a), .o_tx_byte(tx_byte_a),
    .i_tx_active(tx_active_a), .i_tx_done(tx_done_a),
    .i_rx_dv(rx_dv_a), .i_rx_byte(rx_byte_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_pass_cnt(pass_cnt_a), .o_err_cnt(err_cnt_a), .o_tmo_cnt(tmo_cnt_a),
    .o_last_exp(last_exp_a), .o_last_got(last_got_a)
  );

  uart_echo_tester #(
    .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .NUM_BYTES(0),
    .FIRST_CHAR(8'hF0), .CNT_W(8)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_abort(abort_b),
    .o_tx_dv(tx_dv_b), .o_tx_byte(tx_byte_b),
    .i_tx_active(tx_active_b), .i_tx_done(tx_done_b),
    .i_rx_dv(rx_dv_b), .i_rx_byte(rx_byte_b),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_pass_cnt(pass_cnt_b), .o_err_cnt(err_cnt_b), .o_tmo_cnt(tmo_cnt_b),
    .o_last_exp(last_exp_b), .o_last_got(last_got_b)
  );

  // Link model knobs for instance A
  bit flip3  = 0;
  bit silent = 0;
  int dv_len = 1;

  int nsent_a = 0;
  int nsent_b = 0;
  logic [7:0] log_a [0:15];
  logic [7:0] log_b [0:511];
  logic [7:0] eq_a [$];
  logic [7:0] eq_b [$];

  // Transmitter side of link A
  initial begin : tx_model_a
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_dv_a) begin
        b = tx_byte_a;
        if (nsent_a < 16) log_a[nsent_a] = b;
        nsent_a++;
        tx_active_a = 1'b1;
        repeat (FRAME_A) @(negedge clk);
        tx_active_a = 1'b0;
        tx_done_a = 1'b1;
        @(negedge clk);
        tx_done_a = 1'b0;
        if (!silent) eq_a.push_back((flip3 && nsent_a == 3) ? (b ^ 8'h01) : b);
      end
    end
  end

  // Remote echo of link A
  initial begin : rx_model_a
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (eq_a.size() > 0) begin
        b = eq_a.pop_front();
        repeat (DLY_A) @(negedge clk);
        rx_byte_a = b;
        rx_dv_a = 1'b1;
        repeat (dv_len) @(negedge clk);
        rx_dv_a = 1'b0;
      end
    end
  end

  // Transmitter side of link B
  initial begin : tx_model_b
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_dv_b) begin
        b = tx_byte_b;
        if (nsent_b < 512) log_b[nsent_b] = b;
        nsent_b++;
        tx_active_b = 1'b1;
        repeat (FRAME_B) @(negedge clk);
        tx_active_b = 1'b0;
        tx_done_b = 1'b1;
        @(negedge clk);
        tx_done_b = 1'b0;
        eq_b.push_back(b);
      end
    end
  end

  // Remote echo of link B
  initial begin : rx_model_b
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (eq_b.size() > 0) begin
        b = eq_b.pop_front();
        repeat (DLY_B) @(negedge clk);
        rx_byte_b = b;
        rx_dv_b = 1'b1;
        @(negedge clk);
        rx_dv_b = 1'b0;
      end
    end
  end

  // Observers: done pulses, tx_done count, timeout latency
  int done_seen_a = 0;
  int done_seen_b = 0;
  int n_txd_a = 0;
  int n_lat = 0;
  int unsigned t_done = 0;
  int unsigned lat [0:7];
  logic [15:0] tmo_prev = 0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (done_a) done_seen_a++;
      if (done_b) done_seen_b++;
      if (tx_done_a) begin
        n_txd_a++;
        t_done = cyc + 1;
      end
      if (tmo_cnt_a != tmo_prev) begin
        if (tmo_cnt_a > tmo_prev && n_lat < 8) begin
          lat[n_lat] = cyc - t_done;
          n_lat++;
        end
        tmo_prev = tmo_cnt_a;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic run_a(input int budget, output bit ok);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    repeat (12) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_chk++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else n_pass++;
    n_chk++; if (tx_dv_a !== 1'b0) $display("FAIL reset_tx_dv got %b want 0", tx_dv_a); else n_pass++;
    n_chk++; if (done_a !== 1'b0 || pass_a !== 1'b0) $display("FAIL reset_done_pass got %b%b want 00", done_a, pass_a); else n_pass++;
    n_chk++; if ({pass_cnt_a, err_cnt_a, tmo_cnt_a} !== 48'd0) $display("FAIL reset_counts got %h want 0", {pass_cnt_a, err_cnt_a, tmo_cnt_a}); else n_pass++;
    n_chk++; if ({last_exp_a, last_got_a} !== 16'd0) $display("FAIL reset_last got %h want 0000", {last_exp_a, last_got_a}); else n_pass++;
    n_chk++; if (busy_b !== 1'b0) $display("FAIL reset_busy_b got %b want 0", busy_b); else n_pass++;
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_loopback();
    bit ok;
    logic [7:0] e;
    nsent_a = 0;
    done_seen_a = 0;
    run_a(3000, ok);
    n_chk++; if (!ok) $display("FAIL loop_finish got busy want idle"); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      e = 8'h41 + 8'(k);
      n_chk++; if (log_a[k] !== e) $display("FAIL loop_byte%0d got %h want %h", k, log_a[k], e); else n_pass++;
    end
    n_chk++; if (nsent_a != 4) $display("FAIL loop_nsent got %0d want 4", nsent_a); else n_pass++;
    n_chk++; if (pass_cnt_a !== 16'd4) $display("FAIL loop_pass_cnt got %0d want 4", pass_cnt_a); else n_pass++;
    n_chk++; if (err_cnt_a !== 16'd0 || tmo_cnt_a !== 16'd0) $display("FAIL loop_err_tmo got %0d/%0d want 0/0", err_cnt_a, tmo_cnt_a); else n_pass++;
    n_chk++; if (done_seen_a != 1) $display("FAIL loop_done_pulses got %0d want 1", done_seen_a); else n_pass++;
    n_chk++; if (pass_a !== 1'b1) $display("FAIL loop_pass got %b want 1", pass_a); else n_pass++;
  endtask

  task automatic test_mismatch();
    bit ok;
    nsent_a = 0;
    flip3 = 1'b1;
    run_a(3000, ok);
    flip3 = 1'b0;
    n_chk++; if (!ok) $display("FAIL mis_finish got busy want idle"); else n_pass++;
    n_chk++; if (err_cnt_a !== 16'd1) $display("FAIL mis_err_cnt got %0d want 1", err_cnt_a); else n_pass++;
    n_chk++; if (pass_cnt_a !== 16'd3) $display("FAIL mis_pass_cnt got %0d want 3", pass_cnt_a); else n_pass++;
    n_chk++; if (last_exp_a !== 8'h43) $display("FAIL mis_last_exp got %h want 43", last_exp_a); else n_pass++;
    n_chk++; if (last_got_a !== 8'h42) $display("FAIL mis_last_got got %h want 42", last_got_a); else n_pass++;
    n_chk++; if (pass_a !== 1'b0) $display("FAIL mis_pass got %b want 0", pass_a); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    nsent_a = 0;
    n_lat = 0;
    silent = 1'b1;
    run_a(5000, ok);
    silent = 1'b0;
    n_chk++; if (!ok) $display("FAIL tmo_finish got busy want idle"); else n_pass++;
    n_chk++; if (tmo_cnt_a !== 16'd4) $display("FAIL tmo_cnt got %0d want 4", tmo_cnt_a); else n_pass++;
    n_chk++; if (n_lat != 4) $display("FAIL tmo_events got %0d want 4", n_lat); else n_pass++;
    for (int k = 0; k < 4 && k < n_lat; k++) begin
      n_chk++; if (lat[k] != 300) $display("FAIL tmo_latency%0d got %0d want 300", k, lat[k]); else n_pass++;
    end
    n_chk++; if (pass_cnt_a !== 16'd0) $display("FAIL tmo_pass_cnt got %0d want 0", pass_cnt_a); else n_pass++;
    n_chk++; if (pass_a !== 1'b0) $display("FAIL tmo_pass got %b want 0", pass_a); else n_pass++;
  endtask

  task automatic test_long_dv();
    bit ok;
    nsent_a = 0;
    done_seen_a = 0;
    dv_len = 5;
    run_a(3000, ok);
    dv_len = 1;
    n_chk++; if (!ok) $display("FAIL longdv_finish got busy want idle"); else n_pass++;
    n_chk++; if (pass_cnt_a !== 16'd4) $display("FAIL longdv_pass_cnt got %0d want 4", pass_cnt_a); else n_pass++;
    n_chk++; if (err_cnt_a !== 16'd0 || tmo_cnt_a !== 16'd0) $display("FAIL longdv_err_tmo got %0d/%0d want 0/0", err_cnt_a, tmo_cnt_a); else n_pass++;
    n_chk++; if (done_seen_a != 1) $display("FAIL longdv_done got %0d want 1", done_seen_a); else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    nsent_a = 0;
    done_seen_a = 0;
    n_txd_a = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (n_txd_a >= 2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_chk++; if (!ok) $display("FAIL abort_reach_byte2 got %0d tx_done want 2", n_txd_a); else n_pass++;
    repeat (3) step();
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    n_chk++; if (busy_a !== 1'b0) $display("FAIL abort_idle got busy=%b want 0", busy_a); else n_pass++;
    n_chk++; if (pass_cnt_a !== 16'd1) $display("FAIL abort_pass_cnt got %0d want 1", pass_cnt_a); else n_pass++;
    repeat (40) step();
    n_chk++; if (pass_cnt_a !== 16'd1 || err_cnt_a !== 16'd0) $display("FAIL abort_late_echo got %0d/%0d want 1/0", pass_cnt_a, err_cnt_a); else n_pass++;
    n_chk++; if (done_seen_a != 0) $display("FAIL abort_no_done got %0d want 0", done_seen_a); else n_pass++;
    n_chk++; if (busy_a !== 1'b0) $display("FAIL abort_stay_idle got %b want 0", busy_a); else n_pass++;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n_chk++; if (pass_cnt_a !== 16'd0 || busy_a !== 1'b1) $display("FAIL abort_restart_clear got cnt=%0d busy=%b want 0/1", pass_cnt_a, busy_a); else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy_a) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_chk++; if (!ok || pass_cnt_a !== 16'd4) $display("FAIL abort_rerun got cnt=%0d done=%b want 4/1", pass_cnt_a, ok); else n_pass++;
    n_chk++; if (done_seen_a != 1) $display("FAIL abort_rerun_done got %0d want 1", done_seen_a); else n_pass++;
    repeat (12) step();
  endtask

  task automatic test_continuous();
    bit ok;
    int bad;
    logic [7:0] e;
    nsent_b = 0;
    done_seen_b = 0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (nsent_b > 300) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_chk++; if (!ok) $display("FAIL cont_reach_300 got %0d bytes want >300", nsent_b); else n_pass++;
    n_chk++; if (busy_b !== 1'b1) $display("FAIL cont_still_busy got %b want 1", busy_b); else n_pass++;
    abort_b = 1'b1;
    step();
    abort_b = 1'b0;
    n_chk++; if (busy_b !== 1'b0) $display("FAIL cont_abort got busy=%b want 0", busy_b); else n_pass++;
    n_chk++; if (log_b[0] !== 8'hF0) $display("FAIL cont_byte0 got %h want f0", log_b[0]); else n_pass++;
    n_chk++; if (log_b[16] !== 8'h00) $display("FAIL cont_byte16 got %h want 00", log_b[16]); else n_pass++;
    n_chk++; if (log_b[26] !== 8'hF0) $display("FAIL cont_byte26 got %h want f0", log_b[26]); else n_pass++;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      e = 8'hF0 + 8'(k % 26);
      if (log_b[k] !== e) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL cont_pattern got %0d wrong bytes want 0", bad); else n_pass++;
    n_chk++; if (pass_cnt_b !== 8'hFF) $display("FAIL cont_saturate got %0d want 255", pass_cnt_b); else n_pass++;
    n_chk++; if (err_cnt_b !== 8'd0 || tmo_cnt_b !== 8'd0) $display("FAIL cont_err_tmo got %0d/%0d want 0/0", err_cnt_b, tmo_cnt_b); else n_pass++;
    n_chk++; if (done_seen_b != 0) $display("FAIL cont_no_done got %0d want 0", done_seen_b); else n_pass++;
  endtask

  initial begin : main
    test_reset();
    test_loopback();
    test_mismatch();
    test_timeout();
    test_long_dv();
    test_abort();
    test_continuous();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
